xor_cipher_scheduler: RTL
=========================

XOR_CIPHER_SCHEDULER -- requirements
Module: xor_cipher_scheduler

Interface
REQ-001 The block SHALL have port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port clr: input, 1 bit, asynchronous, active-high reset.
REQ-003 The block SHALL have port key_load: input, 1 bit, strobe that loads key_in into the key register.
REQ-004 The block SHALL have port key_in: input, 8 bits, new cipher key.
REQ-005 The block SHALL have ports req0_valid and req1_valid: inputs, 1 bit each, requester n has a byte to encrypt.
REQ-006 The block SHALL have ports req0_data and req1_data: inputs, 8 bits each, plaintext byte of requester n.
REQ-007 The block SHALL have ports req0_ready and req1_ready: outputs, 1 bit each, high for exactly the cycle in which the byte of requester n is accepted.
REQ-008 The block SHALL have port xor_data: output, 8 bits, registered plaintext driven to the XOR stage data input.
REQ-009 The block SHALL have port xor_key: output, 8 bits, current key driven to the XOR stage key input.
REQ-010 The block SHALL have port reg_load: output, 1 bit, one-cycle capture strobe to the PIPO result register.
REQ-011 The block SHALL have port reg_q: input, 8 bits, PIPO register output (ciphertext).
REQ-012 The block SHALL have ports out_valid (output, 1 bit), out_data (output, 8 bits), out_tag (output, 1 bit, id of the granted requester) and out_ready (input, 1 bit), forming the result handshake.
REQ-013 The block SHALL have ports busy (output, 1 bit, FSM not IDLE) and key_valid (output, 1 bit, key loaded since reset).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD and HOLD.
REQ-015 In IDLE with key_valid=1, key_load=0 and at least one reqN_valid=1, the block SHALL grant one requester, assert its reqN_ready combinationally, capture reqN_data into xor_data, capture the id into out_tag and go to LOAD.
REQ-016 Arbitration SHALL be round-robin: a last-grant bit starts at 1 so requester 0 wins first, the requester other than the last grant wins a tie, and a sole requester always wins.
REQ-017 LOAD SHALL assert reg_load for exactly one cycle and go to HOLD.
REQ-018 HOLD SHALL assert out_valid with out_data=reg_q; on out_valid and out_ready the block SHALL return to IDLE and update last-grant; otherwise out_valid, out_data and out_tag SHALL hold steady.
REQ-019 Latency SHALL be: accept in cycle N, reg_load in N+1, out_valid from N+2; throughput is at most one byte per 3 cycles.
REQ-020 key_load SHALL update the key register only in IDLE, and SHALL then take priority: no grant in that cycle.
REQ-021 key_load in LOAD or HOLD SHALL be ignored, and the in-flight byte SHALL use the old key.
REQ-022 No grant SHALL occur while key_valid=0; requesters SHALL stall with ready=0.
REQ-023 reqN_ready SHALL never be asserted outside IDLE, and never for both requesters in one cycle.
REQ-024 Valid inputs deasserted before grant SHALL be treated as withdrawn, with no side effect.

Reset
REQ-025 Assertion of clr SHALL asynchronously force: state=IDLE, key=8'h00, key_valid=0, xor_data=8'h00, out_tag=0, last-grant=1, and reg_load, out_valid, busy, req0_ready and req1_ready all 0.
REQ-026 clr asserted mid-operation (LOAD or HOLD) SHALL drop the in-flight byte without an out_valid pulse; after clr, a key_load SHALL be required again.

Configuration
REQ-027 With KEY_ROLL_EN defined, the key register SHALL rotate left by 1 on every completed output handshake, and key_load SHALL override the rotation.
REQ-028 Without KEY_ROLL_EN, the key SHALL change only on key_load.

Verification
REQ-029 The bench SHALL cover: clr; key_load with key_in=8'hA5; req0 valid with 8'h3C; out_ready=1 -> req0_ready in N, reg_load in N+1, out_valid in N+2 with out_data=8'h99 and out_tag=0.
REQ-030 The bench SHALL cover: both requesters valid continuously (8'h01 and 8'h02), key 8'hFF -> grants alternate 0,1,0,1 with outputs 8'hFE, 8'hFD, 8'hFE, 8'hFD.
REQ-031 The bench SHALL cover: request with no key loaded since clr -> req ready stays 0 and no grant; key_load then releases the grant on the next cycle.
REQ-032 The bench SHALL cover: key_load=8'h0F during HOLD of an 8'hA5-keyed byte -> that output still uses 8'hA5, and the next byte uses 8'h0F.
REQ-033 The bench SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_valid, out_data and out_tag stable, and no new req ready.
REQ-034 The bench SHALL cover: clr pulsed in LOAD -> all outputs zero immediately, no out_valid, and key_valid=0; with KEY_ROLL_EN, key 8'h81 after one output becomes 8'h03.

Source files
------------

// File: rtl/xor_cipher_scheduler.sv
// Two-requester round-robin front end for an external XOR stage and PIPO result register.
// Optional build macro KEY_ROLL_EN: rotate the key left by one after every completed output handshake.

module xor_cipher_scheduler (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_load,
  input  logic [7:0] key_in,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [7:0] xor_data,
  output logic [7:0] xor_key,
  output logic       reg_load,
  input  logic [7:0] reg_q,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_tag,
  input  logic       out_ready,
  output logic       busy,
  output logic       key_valid,
  output logic [1:0] state_o
);

  // Handshakes: a byte moves on a rising edge where valid and ready are both high.
  // reqN_ready is a combinational reply to reqN_valid; out_valid never waits on out_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] xor_data_q, xor_data_d;
  logic       out_tag_q, out_tag_d;
  logic       last_grant_q, last_grant_d;
  logic       grant_any;
  logic       grant_id;

  // On a tie the requester that did not win last time goes first.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      key_q        <= 8'h00;
      key_valid_q  <= 1'b0;
      xor_data_q   <= 8'h00;
      out_tag_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      xor_data_q   <= xor_data_d;
      out_tag_q    <= out_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    xor_data_d   = xor_data_q;
    out_tag_d    = out_tag_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    reg_load     = 1'b0;
    out_valid    = 1'b0;
    out_data     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (key_load) begin
          key_d       = key_in;
          key_valid_d = 1'b1;
        end else if (key_valid_q && grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          xor_data_d = grant_id ? req1_data : req0_data;
          out_tag_d  = grant_id;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        reg_load = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        out_data  = reg_q;
        if (out_ready) begin
          state_d      = S_IDLE;
          last_grant_d = out_tag_q;
`ifdef KEY_ROLL_EN
          key_d        = {key_q[6:0], key_q[7]};
`else
          key_d        = key_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xor_data  = xor_data_q;
  assign xor_key   = key_q;
  assign out_tag   = out_tag_q;
  assign busy      = (state_q != S_IDLE);
  assign key_valid = key_valid_q;
  assign state_o   = state_q;

endmodule
